// File: rtl/craps_pkg.sv
// Craps rules engine shared types and constants.
// Holds the game state enum and the sums the rules test against.
package craps_pkg;

  typedef enum logic [1:0] {
    COME_OUT = 2'd0,
    POINT    = 2'd1,
    WIN      = 2'd2,
    LOSE     = 2'd3
  } state_t;

  localparam logic [3:0] SUM_TWO    = 4'd2;
  localparam logic [3:0] SUM_THREE  = 4'd3;
  localparam logic [3:0] SUM_SEVEN  = 4'd7;
  localparam logic [3:0] SUM_ELEVEN = 4'd11;
  localparam logic [3:0] SUM_TWELVE = 4'd12;

  localparam logic [7:0] ROLL_CNT_MAX = 8'd255;

  function automatic logic [3:0] dice_sum(
    input logic [2:0] a,
    input logic [2:0] b
  );
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one registered delay and an AND-NOT.
// Ports: clk, rst (sync, high), d level in, rise pulse out.
module rise_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Resetting to 1 keeps a level already high at reset release
  // from looking like a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) d_q <= RST_VAL;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/craps_game.sv
// Craps rules engine: scores each settled roll, holds win/lose.
// Ports: clk, rst, die_a/die_b, choose, new_game -> sum, point, win, lose, roll_count.
module craps_game
  import craps_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] die_a,
  input  logic [2:0] die_b,
  input  logic       choose,
  input  logic       new_game,
  output logic [3:0] sum,
  output logic [3:0] point,
  output logic       win,
  output logic       lose,
  output logic [7:0] roll_count
);

  state_t     state;
  logic       choose_rise;
  logic       roll_ev;
  logic [3:0] roll_sum;
  logic [7:0] cnt_next;

  rise_detect #(
    .RST_VAL(1'b1)
  ) u_rise (
    .clk (clk),
    .rst (rst),
    .d   (choose),
    .rise(choose_rise)
  );

  // A zero face means the die never rolled; the edge is dropped.
  assign roll_ev  = choose_rise & (|die_a) & (|die_b);
  assign roll_sum = dice_sum(die_a, die_b);
  assign cnt_next = (roll_count == ROLL_CNT_MAX) ?
                    roll_count : roll_count + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COME_OUT;
      sum        <= '0;
      point      <= '0;
      roll_count <= '0;
      win        <= 1'b0;
      lose       <= 1'b0;
    end else begin
      unique case (state)
        COME_OUT: begin
          if (roll_ev) begin
            sum        <= roll_sum;
            roll_count <= cnt_next;
            unique case (1'b1)
              (roll_sum == SUM_SEVEN),
              (roll_sum == SUM_ELEVEN): begin
                state <= WIN;
                win   <= 1'b1;
              end
              (roll_sum == SUM_TWO),
              (roll_sum == SUM_THREE),
              (roll_sum == SUM_TWELVE): begin
                state <= LOSE;
                lose  <= 1'b1;
              end
              default: begin
                state <= POINT;
                point <= roll_sum;
              end
            endcase
          end
        end
        POINT: begin
          if (roll_ev) begin
            sum        <= roll_sum;
            roll_count <= cnt_next;
            // Point can never be 7, so the order here is only formal.
            if (roll_sum == point) begin
              state <= WIN;
              win   <= 1'b1;
            end else if (roll_sum == SUM_SEVEN) begin
              state <= LOSE;
              lose  <= 1'b1;
            end
          end
        end
        WIN, LOSE: begin
          if (new_game) begin
            state      <= COME_OUT;
            sum        <= '0;
            point      <= '0;
            roll_count <= '0;
            win        <= 1'b0;
            lose       <= 1'b0;
          end
        end
        default: begin
          state <= COME_OUT;
          win   <= 1'b0;
          lose  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/craps_game.md
# craps_game

Craps rules engine that consumes settled dice values from two roll counters sharing one button and decides win/lose. Each release of the roll button (rising edge of the counters' `choose` level) is one roll event: the two die faces are summed, the come-out/point rules are applied, and the result is held until the player starts a new game. It sits between the roll counters and the seven-segment/LED display logic.

## Interface
- No parameters; all widths fixed (faces 3 bits, sum/point 4 bits, roll count 8 bits).
- `clk` in 1: single system clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `die_a` in 3: face of die A, 1–6 valid, 0 = not yet rolled.
- `die_b` in 3: face of die B, same encoding.
- `choose` in 1: level from the roll counters, high while dice are settled (button released after a roll).
- `new_game` in 1: level request to start a new game; honoured only in WIN or LOSE.
- `sum` out 4: registered sum of the last accepted roll (2–12), 0 after reset/new game.
- `point` out 4: established point (4,5,6,8,9,10), 0 when no point.
- `win` out 1: high while in WIN.
- `lose` out 1: high while in LOSE.
- `roll_count` out 8: accepted rolls in the current game, saturates at 255.

## Operation
- Roll event = `choose` & ~`choose_q` & (`die_a` != 0) & (`die_b` != 0); `choose_q` is `choose` delayed one cycle.
- Edge with a zero face is consumed (`choose_q` still updates) but ignored: no state, sum, or count change.
- States: COME_OUT, POINT, WIN, LOSE. Reset → COME_OUT.
- COME_OUT on event: `sum` ← a+b; 7 or 11 → WIN; 2, 3, 12 → LOSE; otherwise `point` ← a+b, → POINT.
- POINT on event: `sum` ← a+b; sum == `point` → WIN; sum == 7 → LOSE; otherwise stay.
- Every accepted event in COME_OUT/POINT increments `roll_count` (saturating, 255 + 1 = 255).
- WIN/LOSE: roll events ignored; `sum`, `point`, `roll_count` frozen.
- WIN/LOSE with `new_game` high → COME_OUT; `sum`, `point`, `roll_count` cleared to 0.
- `new_game` in COME_OUT/POINT: no effect.
- `new_game` and a roll event in the same cycle in WIN/LOSE: `new_game` wins; the edge is consumed and not scored.
- Sum arithmetic: 3-bit + 3-bit zero-extended into 4 bits; no overflow for valid faces.

## Timing
- Reset values: `sum`=0, `point`=0, `win`=0, `lose`=0, `roll_count`=0, state COME_OUT, `choose_q`=1.
- `choose_q` resets to 1, so `choose` held high across reset release is not a roll.
- Latency: the first cycle `choose` is sampled high produces the event; all outputs update at that posedge and are visible the following cycle (1 cycle).
- `win`/`lose` are decoded from the registered state, are glitch-free, and are never both high.
- `rst` mid-game takes effect at the next posedge regardless of state or pending event.
- Back-to-back events require `choose` to fall and rise again; a level held high scores once.

## Structure
- `craps_pkg`: `state_t` enum (COME_OUT, POINT, WIN, LOSE), constants `SUM_SEVEN`=7, `SUM_ELEVEN`=11, `SUM_TWO`=2, `SUM_THREE`=3, `SUM_TWELVE`=12, `ROLL_CNT_MAX`=255.
- Sub-module `rise_detect` (registered delay plus AND-NOT, with reset value parameterised to 1); the rest is one FSM plus datapath registers in `craps_game`.

## Test plan
- Reset, then `choose` rises with die_a=3, die_b=4 → next cycle `sum`=7, `win`=1, `roll_count`=1; a later rise with 1/1 leaves all outputs unchanged.
- Come-out 2/2 → `point`=4, state POINT; roll 6/1 → `lose`=1, `sum`=7; `new_game`=1 → `sum`=`point`=`roll_count`=0, `win`=`lose`=0.
- Come-out 5/5 (point 10), then 3/3, 2/2, 4/6 → `win`=1, `roll_count`=4, `point`=10.
- Come-out 1/1, 1/2, and 6/6 each from a fresh game → `lose`=1 every time, `point`=0.
- `choose` held high through `rst` deassertion → no event; edge with die_a=0 → ignored; `new_game` and a roll edge in the same cycle in WIN → COME_OUT with `roll_count`=0.
- 300 non-resolving rolls in POINT (point 6, alternating 4/4 and 5/4) → `roll_count` saturates at 255.
